axis_frame_checker: RTL and testbench

- Synthesizable stream sink placed directly downstream of hls_target. It consumes the 3-channel hw_output_1 AXI-Stream (TDATA_0/1/2, TVALID, TREADY, TLAST).
- Drives TREADY from a programmable stall pattern to exercise DUT back-pressure.
- Tracks row/column/frame position, flags TLAST misplacement and folds every accepted pixel into a 32-bit checksum the bench compares against the golden model.

---
 rtl/axis_frame_checker_pkg.sv | 20 ++
 rtl/axis_pos_tracker.sv | 49 ++++
 rtl/axis_frame_checker.sv | 116 +++++++++++
 tb/tb_axis_frame_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_checker_pkg.sv
// Shared definitions for the AXI-Stream frame checker and its bench models.
package axis_frame_checker_pkg;

   // Default frame geometry. The stream models use the same values.
   localparam int IMG_W_DEF = 64;
   localparam int IMG_H_DEF = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_e;

   // Checksum step: rotate left by one, then XOR in the pixel word.
   function automatic logic [31:0] cs_update(input logic [31:0] cs,
                                             input logic [31:0] pix);
      return {cs[30:0], cs[31]} ^ pix;
   endfunction

endpackage

// File: rtl/axis_pos_tracker.sv
// Column/row position tracker. It flags the end of a frame and any TLAST
// placement error for each accepted beat.
module axis_pos_tracker
   import axis_frame_checker_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic beat,
   input  logic last_in,
   output logic frame_end,
   output logic err_early,
   output logic err_missing
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          final_pix;

   assign final_pix   = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
   // A TLAST ends the frame wherever it lands, which resynchronises on it.
   assign frame_end   = beat && (final_pix || last_in);
   assign err_early   = beat && last_in && !final_pix;
   assign err_missing = beat && !last_in && final_pix;

   // Advance the position on every accepted beat and clear it at frame end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (frame_end) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/axis_frame_checker.sv
// Stream sink for the 3-channel output stream. It drives TREADY from a fixed
// stall pattern, counts beats and frames, checks TLAST placement and keeps a
// rotating XOR checksum of every accepted pixel.
// Handshake: a beat transfers on a rising clk edge where valid && ready;
// ready depends only on registered state and the pattern pointer, never on
// valid.
module axis_frame_checker
   import axis_frame_checker_pkg::*;
#(
   parameter int          IMG_W     = IMG_W_DEF,
   parameter int          IMG_H     = IMG_H_DEF,
   parameter int          CH_W      = 8,
   parameter logic [15:0] STALL_PAT = 16'hFFFF,
   parameter int          ERR_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic [CH_W-1:0]  data_in0,
   input  logic [CH_W-1:0]  data_in1,
   input  logic [CH_W-1:0]  data_in2,
   input  logic             valid,
   input  logic             last_in,
   output logic             ready,
   output logic [31:0]      pix_count,
   output logic [15:0]      frame_count,
   output logic [31:0]      checksum,
   output logic [ERR_W-1:0] err_early,
   output logic [ERR_W-1:0] err_missing,
   output logic             done
);

   localparam int DW = 3 * CH_W;

   chk_state_e state, state_next;
   logic [3:0] ptr;
   logic       beat;
   logic       frame_end, early_stb, missing_stb;

   logic [DW-1:0] pix_cat;
   logic [31:0]   pix_word;

   assign pix_cat = {data_in2, data_in1, data_in0};

   generate
      if (DW >= 32) begin : g_trunc
         assign pix_word = pix_cat[31:0];
      end else begin : g_ext
         assign pix_word = {{(32 - DW){1'b0}}, pix_cat};
      end
   endgenerate

   assign beat = valid && ready;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and state-decoded outputs; DONE is terminal until reset.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start_in) state_next = RUN;
         RUN: begin
            ready = STALL_PAT[ptr];
            if (stop_in) state_next = DONE;
         end
         DONE: done = 1'b1;
         default: state_next = IDLE;
      endcase
   end

   // Stall pattern pointer steps every RUN cycle, handshake or not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            ptr <= '0;
      else if (state == RUN) ptr <= ptr + 4'd1;
   end

   axis_pos_tracker #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pos (
      .clk         (clk),
      .reset       (reset),
      .beat        (beat),
      .last_in     (last_in),
      .frame_end   (frame_end),
      .err_early   (early_stb),
      .err_missing (missing_stb)
   );

   // Statistics update on accepted beats only; error counters saturate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_count   <= '0;
         frame_count <= '0;
         checksum    <= '0;
         err_early   <= '0;
         err_missing <= '0;
      end else if (beat) begin
         pix_count <= pix_count + 32'd1;
         checksum  <= cs_update(checksum, pix_word);
         if (frame_end) frame_count <= frame_count + 16'd1;
         if (early_stb && (err_early != {ERR_W{1'b1}}))
            err_early <= err_early + ERR_W'(1);
         if (missing_stb && (err_missing != {ERR_W{1'b1}}))
            err_missing <= err_missing + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker on a 4x2 frame. Instance a never
// stalls; instance b uses an alternating stall pattern. Both share inputs.
module tb_axis_frame_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_in, stop_in, valid, last_in;
   logic [7:0] data_in0, data_in1, data_in2;

   logic        ready_a, done_a, ready_b, done_b;
   logic [31:0] pix_a, cs_a, pix_b, cs_b;
   logic [15:0] frame_a, frame_b;
   logic [7:0]  ee_a, em_a, ee_b, em_b;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   axis_frame_checker #(.IMG_W(4), .IMG_H(2), .CH_W(8), .STALL_PAT(16'hFFFF), .ERR_W(8)) dut_a (
      .clk(clk), .reset(rst_n), .start_in(start_in), .stop_in(stop_in),
      .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
      .valid(valid), .last_in(last_in), .ready(ready_a),
      .pix_count(pix_a), .frame_count(frame_a), .checksum(cs_a),
      .err_early(ee_a), .err_missing(em_a), .done(done_a)
   );

   axis_frame_checker #(.IMG_W(4), .IMG_H(2), .CH_W(8), .STALL_PAT(16'hAAAA), .ERR_W(8)) dut_b (
      .clk(clk), .reset(rst_n), .start_in(start_in), .stop_in(stop_in),
      .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
      .valid(valid), .last_in(last_in), .ready(ready_b),
      .pix_count(pix_b), .frame_count(frame_b), .checksum(cs_b),
      .err_early(ee_b), .err_missing(em_b), .done(done_b)
   );

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start_in = 1'b0; stop_in = 1'b0; valid = 1'b0; last_in = 1'b0;
      data_in0 = '0; data_in1 = '0; data_in2 = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk); start_in = 1'b1;
      @(negedge clk); start_in = 1'b0;
   endtask

   // Presents one beat at a falling edge; it transfers on the next rising edge.
   task automatic send_beat(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic last);
      @(negedge clk);
      valid = 1'b1; last_in = last; data_in0 = d0; data_in1 = d1; data_in2 = d2;
      #1;
   endtask

   task automatic go_idle();
      @(negedge clk);
      valid = 1'b0; last_in = 1'b0; stop_in = 1'b0; start_in = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      tests_run++; if (pix_a !== 32'd0) begin fails++; $display("FAIL reset_pix: got %0d expected 0", pix_a); end
      tests_run++; if (frame_a !== 16'd0) begin fails++; $display("FAIL reset_frame: got %0d expected 0", frame_a); end
      tests_run++; if (cs_a !== 32'd0) begin fails++; $display("FAIL reset_cs: got %0h expected 0", cs_a); end
      tests_run++; if (ee_a !== 8'd0 || em_a !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d/%0d expected 0/0", ee_a, em_a); end
      tests_run++; if (ready_a !== 1'b0 || done_a !== 1'b0) begin fails++; $display("FAIL reset_ctl: got ready=%0b done=%0b expected 0/0", ready_a, done_a); end
      tests_run++; if (ready_b !== 1'b0) begin fails++; $display("FAIL reset_ready_b: got %0b expected 0", ready_b); end
   endtask

   task automatic test_single_frame();
      int rdy_bad = 0;
      do_reset();
      do_start();
      for (int i = 1; i <= 8; i++) begin
         send_beat(8'h00, 8'h00, 8'h00, i == 8);
         if (ready_a !== 1'b1) rdy_bad++;
      end
      go_idle();
      tests_run++; if (rdy_bad != 0) begin fails++; $display("FAIL frame_ready: got %0d low cycles expected 0", rdy_bad); end
      tests_run++; if (pix_a !== 32'd8) begin fails++; $display("FAIL frame_pix: got %0d expected 8", pix_a); end
      tests_run++; if (frame_a !== 16'd1) begin fails++; $display("FAIL frame_count: got %0d expected 1", frame_a); end
      tests_run++; if (cs_a !== 32'd0) begin fails++; $display("FAIL frame_cs: got %0h expected 0", cs_a); end
      tests_run++; if (ee_a !== 8'd0 || em_a !== 8'd0) begin fails++; $display("FAIL frame_err: got %0d/%0d expected 0/0", ee_a, em_a); end
   endtask

   task automatic test_checksum();
      do_reset();
      do_start();
      send_beat(8'h01, 8'h00, 8'h00, 1'b0);
      send_beat(8'h01, 8'h00, 8'h00, 1'b0);
      tests_run++; if (cs_a !== 32'h1) begin fails++; $display("FAIL cs_beat1: got %0h expected 1", cs_a); end
      go_idle();
      tests_run++; if (cs_a !== 32'h3) begin fails++; $display("FAIL cs_beat2: got %0h expected 3", cs_a); end
      // Fresh run: channel ordering and rotation with wider values.
      do_reset();
      do_start();
      send_beat(8'h56, 8'h34, 8'h12, 1'b0);
      send_beat(8'h00, 8'h00, 8'hFF, 1'b0);
      tests_run++; if (cs_a !== 32'h00123456) begin fails++; $display("FAIL cs_order: got %0h expected 00123456", cs_a); end
      go_idle();
      tests_run++; if (cs_a !== 32'h00DB68AC) begin fails++; $display("FAIL cs_rotate: got %0h expected 00db68ac", cs_a); end
   endtask

   task automatic test_early_last();
      do_reset();
      do_start();
      for (int i = 1; i <= 5; i++) send_beat(8'h00, 8'h00, 8'h00, i == 5);
      go_idle();
      tests_run++; if (ee_a !== 8'd1) begin fails++; $display("FAIL early_err: got %0d expected 1", ee_a); end
      tests_run++; if (frame_a !== 16'd1) begin fails++; $display("FAIL early_frame1: got %0d expected 1", frame_a); end
      for (int i = 1; i <= 8; i++) send_beat(8'h00, 8'h00, 8'h00, i == 8);
      go_idle();
      tests_run++; if (frame_a !== 16'd2) begin fails++; $display("FAIL early_frame2: got %0d expected 2", frame_a); end
      tests_run++; if (ee_a !== 8'd1 || em_a !== 8'd0) begin fails++; $display("FAIL early_resync: got %0d/%0d expected 1/0", ee_a, em_a); end
   endtask

   task automatic test_missing_last();
      do_reset();
      do_start();
      for (int i = 1; i <= 8; i++) send_beat(8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 1; i <= 8; i++) send_beat(8'h00, 8'h00, 8'h00, i == 8);
      go_idle();
      tests_run++; if (em_a !== 8'd1) begin fails++; $display("FAIL missing_err: got %0d expected 1", em_a); end
      tests_run++; if (frame_a !== 16'd2) begin fails++; $display("FAIL missing_frame: got %0d expected 2", frame_a); end
      for (int i = 0; i < 300 * 8; i++) send_beat(8'h00, 8'h00, 8'h00, 1'b0);
      go_idle();
      tests_run++; if (em_a !== 8'd255) begin fails++; $display("FAIL missing_sat: got %0d expected 255", em_a); end
      tests_run++; if (frame_a !== 16'd302) begin fails++; $display("FAIL missing_frames: got %0d expected 302", frame_a); end
      tests_run++; if (pix_a !== 32'd2416) begin fails++; $display("FAIL missing_pix: got %0d expected 2416", pix_a); end
      tests_run++; if (ee_a !== 8'd0) begin fails++; $display("FAIL missing_early: got %0d expected 0", ee_a); end
   endtask

   task automatic test_stall_pattern();
      int rdy_bad = 0;
      do_reset();
      @(negedge clk); start_in = 1'b1;
      @(negedge clk); start_in = 1'b0; valid = 1'b1; last_in = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (ready_b !== ((i % 2) == 1)) begin
            rdy_bad++;
            $display("FAIL stall_ready_c%0d: got %0b expected %0b", i, ready_b, (i % 2) == 1);
         end
      end
      tests_run++; if (rdy_bad != 0) fails++;
      go_idle();
      tests_run++; if (pix_b !== 32'd8) begin fails++; $display("FAIL stall_pix: got %0d expected 8", pix_b); end
   endtask

   task automatic test_stop();
      do_reset();
      do_start();
      send_beat(8'h00, 8'h00, 8'h00, 1'b0);
      send_beat(8'h00, 8'h00, 8'h00, 1'b0);
      send_beat(8'h00, 8'h00, 8'h00, 1'b0);
      stop_in = 1'b1;
      go_idle();
      tests_run++; if (done_a !== 1'b1 || ready_a !== 1'b0) begin fails++; $display("FAIL stop_ctl: got done=%0b ready=%0b expected 1/0", done_a, ready_a); end
      tests_run++; if (pix_a !== 32'd3) begin fails++; $display("FAIL stop_pix: got %0d expected 3", pix_a); end
      @(negedge clk); valid = 1'b1; start_in = 1'b1;
      @(negedge clk); start_in = 1'b0;
      repeat (3) @(negedge clk);
      valid = 1'b0;
      tests_run++; if (pix_a !== 32'd3) begin fails++; $display("FAIL stop_ignore: got %0d expected 3", pix_a); end
      tests_run++; if (done_a !== 1'b1 || ready_a !== 1'b0) begin fails++; $display("FAIL stop_hold: got done=%0b ready=%0b expected 1/0", done_a, ready_a); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      do_start();
      send_beat(8'h11, 8'h22, 8'h33, 1'b0);
      send_beat(8'h44, 8'h55, 8'h66, 1'b0);
      go_idle();
      tests_run++; if (pix_a !== 32'd2) begin fails++; $display("FAIL midrst_pre: got %0d expected 2", pix_a); end
      @(negedge clk); rst_n = 1'b0;
      #1;
      tests_run++; if (pix_a !== 32'd0 || cs_a !== 32'd0 || frame_a !== 16'd0) begin fails++; $display("FAIL midrst_stats: got %0d/%0h/%0d expected 0/0/0", pix_a, cs_a, frame_a); end
      tests_run++; if (ready_a !== 1'b0 || done_a !== 1'b0) begin fails++; $display("FAIL midrst_ctl: got ready=%0b done=%0b expected 0/0", ready_a, done_a); end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (ready_a !== 1'b0) begin fails++; $display("FAIL midrst_idle: got ready=%0b expected 0", ready_a); end
      do_start();
      for (int i = 1; i <= 8; i++) send_beat(8'h00, 8'h00, 8'h00, i == 8);
      go_idle();
      tests_run++; if (frame_a !== 16'd1 || ee_a !== 8'd0 || em_a !== 8'd0) begin fails++; $display("FAIL midrst_frame: got %0d/%0d/%0d expected 1/0/0", frame_a, ee_a, em_a); end
   endtask

   initial begin
      rst_n = 1'b0; start_in = 1'b0; stop_in = 1'b0; valid = 1'b0; last_in = 1'b0;
      data_in0 = '0; data_in1 = '0; data_in2 = '0;
      test_reset();
      test_single_frame();
      test_checksum();
      test_early_last();
      test_missing_last();
      test_stall_pattern();
      test_stop();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
